// File: rtl/spw_light_ctrl_in_if.sv
// -----------------------------------------------------------------------------
// spw_light_ctrl_in_if
// Avalon-MM slave bus bundle for the SpaceWire light control output port.
//   address     3   register word address
//   chipselect  1   slave select
//   write_n     1   active-low write strobe (qualified by chipselect)
//   writedata   32  write data
//   readdata    32  registered read data (slave -> master)
// -----------------------------------------------------------------------------
interface spw_light_ctrl_in_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/spw_light_ctrl_in.sv
// -----------------------------------------------------------------------------
// spw_light_ctrl_in
// Writable Avalon-MM control port driving the SpaceWire light core control
// lines. Supports direct write, atomic bit set/clear and self-timed pulses
// with a programmable length and a per-bit busy readback.
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   bus       slave modport of spw_light_ctrl_in_if (address/cs/write/data)
//   out_port  out  WIDTH control outputs to the core
// Register map (word address):
//   0 DATA      R/W   1 PULSE_LEN R/W   2 PULSE W / busy mask R
//   4 OUTSET    W     5 OUTCLEAR  W     3,6,7 reserved (read 0)
// -----------------------------------------------------------------------------
module spw_light_ctrl_in #(
    parameter int WIDTH         = 2,
    parameter int CNT_W         = 16,
    parameter int PULSE_DEFAULT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    spw_light_ctrl_in_if.slave    bus,
    output logic [WIDTH-1:0]      out_port
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_PLEN   = 3'd1;
    localparam logic [2:0] A_PULSE  = 3'd2;
    localparam logic [2:0] A_OUTSET = 3'd4;
    localparam logic [2:0] A_OUTCLR = 3'd5;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0]             out_q,   out_d;
    logic [WIDTH-1:0][CNT_W-1:0]  cnt_q,   cnt_d;
    logic [CNT_W-1:0]             plen_q,  plen_d;
    logic [31:0]                  rdata_q, rdata_d;

    logic                         wr;
    logic [WIDTH-1:0]             wd;
    logic [WIDTH-1:0]             busy;
    logic [CNT_W-1:0]             plen_eff;

    assign wr       = bus.chipselect & ~bus.write_n;
    assign wd       = bus.writedata[WIDTH-1:0];
    assign plen_eff = (plen_q == '0) ? CNT_ONE : plen_q;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            busy[i] = (cnt_q[i] != '0);
        end
    end

    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        out_d   = out_q;
        cnt_d   = cnt_q;
        plen_d  = plen_q;
        rdata_d = '0;

        // Free-running countdown; the 1->0 step ends the pulse.
        for (int i = 0; i < WIDTH; i++) begin
            if (busy[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
                if (cnt_q[i] == CNT_ONE) begin
                    out_d[i] = 1'b0;
                end
            end
        end

        // Bus writes are applied after the countdown so a write to a bit that
        // expires in the same cycle overrides the expiry.
        if (wr) begin
            case (bus.address)
                A_DATA: begin
                    out_d = wd;
                    cnt_d = '0;
                end
                A_PLEN: plen_d = bus.writedata[CNT_W-1:0];
                A_PULSE: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (wd[i]) begin
                            out_d[i] = 1'b1;
                            cnt_d[i] = plen_eff;
                        end
                    end
                end
                A_OUTSET: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (wd[i]) begin
                            out_d[i] = 1'b1;
                            cnt_d[i] = '0;
                        end
                    end
                end
                A_OUTCLR: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (wd[i]) begin
                            out_d[i] = 1'b0;
                            cnt_d[i] = '0;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Read mux uses current register values, so a same-cycle write is not
        // visible until the following read.
        case (bus.address)
            A_DATA:  rdata_d[WIDTH-1:0] = out_q;
            A_PLEN:  rdata_d[CNT_W-1:0] = plen_q;
            A_PULSE: rdata_d[WIDTH-1:0] = busy;
            default: rdata_d = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    // NOTE: the pulse counters are a handful of flops, not a RAM, so they are
    // reset along with everything else; this kills any running pulse at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= '0;
            cnt_q   <= '0;
            plen_q  <= CNT_W'(PULSE_DEFAULT);
            rdata_q <= '0;
        end else begin
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            plen_q  <= plen_d;
            rdata_q <= rdata_d;
        end
    end

    assign out_port     = out_q;
    assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_spw_light_ctrl_in.sv
// -----------------------------------------------------------------------------
// tb_spw_light_ctrl_in
// Directed scoreboard bench for spw_light_ctrl_in. Stimulus pushes expected
// read responses and out_port/readdata observations into queues; a monitor
// process pops and compares them on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_spw_light_ctrl_in;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] out_port;

    always #5 clk = ~clk;

    spw_light_ctrl_in_if bus ();

    spw_light_ctrl_in #(
        .WIDTH        (2),
        .CNT_W        (16),
        .PULSE_DEFAULT(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .out_port(out_port)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_t;

    typedef struct {
        string       name;
        bit          sel_rdata;
        logic [31:0] exp;
    } obs_t;

    rd_t  rd_q[$];
    obs_t obs_q[$];
    rd_t  rd_item;
    obs_t obs_item;

    logic rd_req   = 1'b0;
    logic rd_vld   = 1'b0;
    logic done     = 1'b0;
    logic mon_done = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: read response is valid on the negedge after the sampling edge.
    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        if (rd_vld) begin
            if (rd_q.size() == 0) begin
                check("rd_q underflow", 32'd1, 32'd0);
            end else begin
                rd_item = rd_q.pop_front();
                check(rd_item.name, bus.readdata, rd_item.exp);
            end
        end
        while (obs_q.size() > 0) begin
            obs_item = obs_q.pop_front();
            check(obs_item.name, obs_item.sel_rdata ? bus.readdata : {30'b0, out_port}, obs_item.exp);
        end
        if (done && !mon_done) begin
            check("rd_q drained", 32'(rd_q.size()), 32'd0);
            mon_done <= 1'b1;
        end
    end

    // All tasks start and end just after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input string name, input logic [31:0] exp);
        rd_t t;
        t.name = name;
        t.exp  = exp;
        rd_q.push_back(t);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        rd_req         = 1'b1;
        step();
        bus.chipselect = 1'b0;
        rd_req         = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] exp);
        obs_t o;
        o.name      = name;
        o.sel_rdata = 1'b0;
        o.exp       = exp;
        obs_q.push_back(o);
    endtask

    task automatic expect_rdata(input string name, input logic [31:0] exp);
        obs_t o;
        o.name      = name;
        o.sel_rdata = 1'b1;
        o.exp       = exp;
        obs_q.push_back(o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;

        // 1 reset
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_out("reset out_port", 0);
        expect_rdata("reset readdata", 0);
        step();
        reset_n = 1'b1;
        step();
        rd(3'd1, "reset PULSE_LEN", 4);

        // 2 direct write and readback
        wr(3'd0, 32'h3);
        expect_out("DATA=3", 3);
        rd(3'd0, "read DATA=3", 3);

        // 3 set / clear, upper writedata bits ignored
        wr(3'd0, 32'hFFFF_FFF1);
        expect_out("DATA=1", 1);
        wr(3'd4, 32'h2);
        expect_out("OUTSET 2", 3);
        wr(3'd5, 32'h1);
        expect_out("OUTCLEAR 1", 2);
        rd(3'd0, "read after OUTCLEAR", 2);
        rd(3'd3, "reserved addr3", 0);

        // 4 five-cycle pulse on bit 0
        wr(3'd0, 32'h0);
        wr(3'd1, 32'hABCD_0005);
        rd(3'd1, "PULSE_LEN=5", 5);
        wr(3'd2, 32'h1);
        for (int k = 0; k <= 6; k++) begin
            expect_out($sformatf("pulse5 k=%0d", k), (k < 5) ? 1 : 0);
            step();
        end
        wr(3'd2, 32'h1);
        step();
        rd(3'd2, "busy during pulse", 1);
        repeat (5) step();
        rd(3'd2, "busy after pulse", 0);
        expect_out("after pulse5", 0);

        // 5 zero length acts as one; retrigger extends the pulse
        wr(3'd1, 32'h0);
        rd(3'd1, "PULSE_LEN=0", 0);
        wr(3'd2, 32'h2);
        for (int k = 0; k <= 2; k++) begin
            expect_out($sformatf("pulse0 k=%0d", k), (k < 1) ? 2 : 0);
            step();
        end
        wr(3'd1, 32'h5);
        wr(3'd2, 32'h2);
        expect_out("retrig k=0", 2);
        step();
        expect_out("retrig k=1", 2);
        step();
        expect_out("retrig k=2", 2);
        wr(3'd2, 32'h2);
        for (int k = 3; k <= 9; k++) begin
            expect_out($sformatf("retrig k=%0d", k), (k < 8) ? 2 : 0);
            step();
        end

        // expiry and OUTSET on the same bit in the same cycle: write wins
        wr(3'd1, 32'h2);
        wr(3'd2, 32'h1);
        expect_out("len2 k=0", 1);
        step();
        wr(3'd4, 32'h1);
        expect_out("OUTSET at expiry", 1);
        rd(3'd2, "busy after OUTSET", 0);
        step();
        expect_out("OUTSET held", 1);
        wr(3'd5, 32'h1);
        expect_out("OUTCLEAR bit0", 0);

        // 6 cancel by DATA write, then reset mid-pulse
        wr(3'd1, 32'h5);
        wr(3'd2, 32'h3);
        expect_out("pulse both", 3);
        step();
        wr(3'd0, 32'h1);
        expect_out("DATA cancel", 1);
        rd(3'd2, "busy after cancel", 0);
        repeat (6) begin
            expect_out("DATA held", 1);
            step();
        end
        wr(3'd2, 32'h2);
        expect_out("pulse before reset", 3);
        step();
        reset_n = 1'b0;
        #1;
        expect_out("async reset out", 0);
        expect_rdata("async reset rdata", 0);
        step();
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            expect_out($sformatf("post-reset k=%0d", k), 0);
            step();
        end
        rd(3'd1, "PULSE_LEN after reset", 4);
        rd(3'd2, "busy after reset", 0);

        step();
        step();
        done = 1'b1;
        for (int i = 0; i < 20 && !mon_done; i++) @(posedge clk);
        #1;
        if (!mon_done) $display("FAIL monitor: did not complete");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
